// File: rtl/mult_table_sequencer.sv
// Multiplication-table sequencer.
// On an accepted start it streams beats (index, multiplicand*index) for index 0..last_index
// under valid/ready handshaking. It then pulses done for one cycle and counts the completed table.
module mult_table_sequencer #(
  parameter int unsigned W_MUL = 4,
  parameter int unsigned W_IDX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [W_MUL-1:0]       multiplicand,
  input  logic [W_IDX-1:0]       last_index,
  input  logic                   abort,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [W_MUL+W_IDX-1:0] result,
  output logic [W_IDX-1:0]       index,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             tables_done
);

  localparam int unsigned WRes = W_MUL + W_IDX;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StFinish
  } state_e;

  state_e           state_q;
  logic [W_MUL-1:0] mcand_q;
  logic [W_IDX-1:0] last_q;
  logic [WRes-1:0]  mcand_ext;

  // Zero-extended operand so the running product accumulates at full result width.
  assign mcand_ext = {{W_IDX{1'b0}}, mcand_q};

  // FSM with all outputs registered; result is built by repeated addition of the multiplicand.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mcand_q     <= '0;
      last_q      <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      index       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tables_done <= 8'd0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          // abort is irrelevant here, so start wins when both are high
          if (start) begin
            mcand_q   <= multiplicand;
            last_q    <= last_index;
            index     <= '0;
            result    <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state_q   <= StEmit;
          end
        end
        StEmit: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end else if (out_ready) begin
            if (index == last_q) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state_q   <= StFinish;
            end else begin
              // Stop at last_q, so index never wraps inside a table
              index  <= index + 1'b1;
              result <= result + mcand_ext;
            end
          end
        end
        StFinish: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          tables_done <= tables_done + 8'd1;
          state_q     <= StIdle;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_table_sequencer.md
MULT_TABLE_SEQUENCER -- requirements
Module: mult_table_sequencer

Interface
REQ-001 Parameter W_MUL, default 4, multiplicand width in bits.
REQ-002 Parameter W_IDX, default 4, index width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new table; sampled only in IDLE.
REQ-006 multiplicand  input  W_MUL  table base; captured on accepted start.
REQ-007 last_index  input  W_IDX  final index of table; captured on accepted start.
REQ-008 abort  input  1  terminate current table.
REQ-009 out_ready  input  1  consumer accepts current beat.
REQ-010 out_valid  output  1  result/index beat valid.
REQ-011 result  output  W_MUL+W_IDX  multiplicand*index, unsigned, full width, no truncation.
REQ-012 index  output  W_IDX  multiplier of current beat.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse after the last beat is accepted.
REQ-015 tables_done  output  8  count of completed (non-aborted) tables.

Function
REQ-016 FSM states SHALL be IDLE, EMIT, FINISH; all outputs registered.
REQ-017 IDLE: start=1 -> capture multiplicand and last_index, index<=0, result<=0, out_valid<=1, go EMIT; start=0 -> stay.
REQ-018 Start-to-first-beat latency SHALL be 1 cycle: out_valid high the cycle after start is sampled.
REQ-019 start SHALL be ignored in EMIT and FINISH; captured operands SHALL not change mid-table.
REQ-020 EMIT, out_ready=0: result, index, out_valid SHALL hold stable (backpressure).
REQ-021 EMIT, out_ready=1, index!=last_index: index<=index+1, result<=captured_multiplicand*(index+1), out_valid stays 1 (one beat per cycle sustained).
REQ-022 EMIT, out_ready=1, index==last_index: out_valid<=0, go FINISH.
REQ-023 FINISH: done=1 for exactly that cycle, tables_done<=tables_done+1, go IDLE.
REQ-024 tables_done SHALL wrap 255 -> 0.
REQ-025 last_index=0 SHALL produce exactly one beat (index 0, result 0) then done.
REQ-026 last_index=2^W_IDX-1 SHALL produce 2^W_IDX beats; index SHALL never wrap within a table.
REQ-027 abort=1 in EMIT: out_valid<=0, go IDLE, no done pulse, tables_done unchanged; abort wins over simultaneous out_ready.
REQ-028 abort in IDLE or FINISH SHALL be ignored; FINISH completes normally.
REQ-029 start and abort together in IDLE: start accepted.
REQ-030 Back-to-back tables: start asserted in the IDLE cycle after FINISH SHALL be accepted; minimum gap last beat -> next first beat is 3 cycles.

Reset
REQ-031 reset=1 SHALL force state IDLE, out_valid=0, result=0, index=0, busy=0, done=0, tables_done=0, captured operands=0.
REQ-032 reset SHALL override start, abort and out_ready in the same cycle, including mid-table; no done pulse.

Verification
REQ-033 reset then start, multiplicand=3, last_index=9, out_ready=1 -> beats (0,0),(1,3)...(9,27) on 10 consecutive cycles, done one cycle later, tables_done=1.
REQ-034 multiplicand=15, last_index=15, out_ready toggled 1/0 -> 16 beats, last (15,225), each value held while out_ready=0, no skipped or duplicated index.
REQ-035 multiplicand=7, last_index=0 -> single beat (0,0), then done pulse, busy low next cycle.
REQ-036 multiplicand=5, last_index=9, abort with out_ready=1 at index 4 -> out_valid low next cycle, no done, tables_done unchanged; start pulses during table ignored.
REQ-037 reset asserted at index 6 of a table -> all outputs at reset values next cycle; new start then yields index 0 beat.
REQ-038 256 completed tables -> tables_done wraps to 0.
